mem_store_unit: RTL
===================

Name: mem_store_unit

Overview:
- MEM-stage store path: the write-direction counterpart of the load filter and writeback path.
- Formats rs2 store data into a word-aligned write with byte strobes and buffers stores in a small in-order FIFO.
- Drains the FIFO to data memory over a req/gnt handshake.
- Stalls the pipeline when the buffer is full, or when a load hits a word that still has a pending store.

Parameters:
- DEPTH, 2, store-buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store instruction present in MEM this cycle.
- ld_valid  input  1  load instruction present in MEM this cycle.
- funct3  input  3  000 = SB, 001 = SH, 010 = SW; other values are illegal.
- addr  input  32  byte address from the ALU.
- rs2_data  input  32  store source register value.
- stall  output  1  combinational; holds the MEM stage this cycle.
- misalign  output  1  registered one-cycle pulse flagging a rejected store.
- dm_req  output  1  head entry valid toward data memory.
- dm_addr  output  32  word address {addr[31:2], 2'b00} of the head entry.
- dm_wdata  output  32  lane-replicated store data of the head entry.
- dm_wstrb  output  4  byte strobes of the head entry.
- dm_gnt  input  1  memory accepts the head entry this cycle.

Behaviour:
- Reset:
  - Synchronous, active-high: clears write/read pointers, occupancy count and misalign.
  - All buffered entries are discarded, including one mid-handshake.
  - dm_req is 0 in the cycle after rst is sampled.
- Empty outputs: dm_req = 0 and dm_addr/dm_wdata/dm_wstrb drive 0 whenever the buffer is empty.
- Formatting, computed at push:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = rs2, wstrb = 4'b1111.
- Misalignment:
  - Misaligned cases: SH with addr[0] = 1; SW with addr[1:0] != 0; any illegal funct3.
  - A misaligned store is not pushed and does not stall.
  - misalign = 1 in the next cycle only.
- Push: st_valid && !misaligned && !full → the entry is written at the write pointer. Pointer wraps modulo DEPTH; count increments.
- Pop: dm_req && dm_gnt → the read pointer advances modulo DEPTH; count decrements.
  - dm_* holds stable while dm_req = 1 and dm_gnt = 0.
  - Entries drain strictly in push order; one pop per cycle maximum.
- Simultaneous push and pop:
  - Not full: both occur and count is unchanged.
  - Full: stall = 1 and no push, even if a pop happens that cycle. The store is retried next cycle.
- Stall:
  - stall = (st_valid && full && !misaligned) || (ld_valid && hazard).
  - hazard = any valid entry whose dm_addr[31:2] equals addr[31:2].
  - Byte-lane overlap is not checked; a match on the word is enough.
- Latency: the earliest dm_req for a store is the cycle after its push. A store pushed into an empty buffer with gnt held high completes in 2 cycles.
- st_valid and ld_valid are mutually exclusive by pipeline contract. If both are high, the store is processed and the load hazard is still evaluated.
- Occupancy: the count ranges 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
  - The count never overflows or underflows: pops are blocked when empty, pushes are blocked when full.

Test Plan:
- SB to addr 0x1003 with rs2 0x000000A5, gnt = 1 → next cycle dm_req = 1, dm_addr 0x1000, dm_wdata 0xA5A5A5A5, dm_wstrb 1000; count returns to 0 one cycle later.
- SH to 0x2002 with rs2 0x1234BEEF → wdata 0xBEEFBEEF, wstrb 1100. SW to 0x2001 → no push, misalign pulses for exactly one cycle, stall stays 0.
- dm_gnt = 0, three SWs back-to-back (DEPTH 2) → third cycle stall = 1. Raise gnt → entries drain in order, third store is accepted once not full, all three dm_addr values appear in issue order.
- Buffer holds SW to 0x3000 and gnt = 0; LW at 0x3002 → stall = 1. LW at 0x3004 → stall = 0. Grant the entry → stall for 0x3002 drops the cycle after the pop.
- Two entries pending, dm_req high with gnt = 0, assert rst one cycle → next cycle dm_req = 0, dm_wstrb 0, a new SB pushes with no stall, and the old data never appears.
- Illegal funct3 011 with st_valid → misalign pulse, no dm_req, count unchanged.

Source files
------------

// File: rtl/mem_store_unit.sv
// MEM-stage store path: formats store data into word writes with byte strobes, buffers them
// in an in-order FIFO and drains the FIFO to data memory over a req/gnt handshake.
module mem_store_unit #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic        ld_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_data,
  output logic        stall,
  output logic        misalign,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_gnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            misalign_q;

  logic [29:0] buf_word_q [DEPTH];
  logic [31:0] buf_data_q [DEPTH];
  logic [3:0]  buf_strb_q [DEPTH];

  logic        full, empty, push, pop, hazard;
  logic        fmt_mis;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_strb;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    fmt_mis  = 1'b0;
    fmt_data = rs2_data;
    fmt_strb = 4'b1111;
    case (funct3)
      3'b000: begin
        fmt_data = {4{rs2_data[7:0]}};
        fmt_strb = 4'b0001 << addr[1:0];
      end
      3'b001: begin
        fmt_data = {2{rs2_data[15:0]}};
        fmt_strb = addr[1] ? 4'b1100 : 4'b0011;
        fmt_mis  = addr[0];
      end
      3'b010:  fmt_mis = (addr[1:0] != 2'b00);
      default: fmt_mis = 1'b1;
    endcase
  end

  assign push = st_valid && !fmt_mis && !full;
  assign pop  = dm_req && dm_gnt;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PtrW-1:0] offs;
    offs   = '0;
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PtrW'(i) - rd_ptr_q;
      if ((CntW'(offs) < count_q) && (buf_word_q[i] == addr[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  assign stall = (st_valid && full && !fmt_mis) || (ld_valid && hazard);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= st_valid && fmt_mis;
    end
  end

  // Payload storage needs no reset; liveness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_word_q[wr_ptr_q] <= addr[31:2];
      buf_data_q[wr_ptr_q] <= fmt_data;
      buf_strb_q[wr_ptr_q] <= fmt_strb;
    end
  end

  assign misalign = misalign_q;
  assign dm_req   = !empty;
  assign dm_addr  = empty ? 32'h0 : {buf_word_q[rd_ptr_q], 2'b00};
  assign dm_wdata = empty ? 32'h0 : buf_data_q[rd_ptr_q];
  assign dm_wstrb = empty ? 4'h0 : buf_strb_q[rd_ptr_q];

endmodule
